// File: rtl/alu_pwr_domain.sv
// Power-gated ALU domain: sequenced switch/isolation FSM wrapped around a
// multi-cycle start/busy/done ALU whose output is clamped while isolated.
module alu_pwr_domain #(
    parameter int unsigned     WIDTH         = 16,
    parameter logic [WIDTH-1:0] CLAMP_VAL    = WIDTH'(1),
    parameter int unsigned     PWR_UP_CYCLES = 4,
    parameter int unsigned     ISO_CYCLES    = 2,
    parameter int unsigned     LATENCY       = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwr_req,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             pwr_en,
    output logic             iso_en,
    output logic             pwr_ack,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] clamp_obs
);

    localparam int unsigned SeqMax = (PWR_UP_CYCLES > ISO_CYCLES) ? PWR_UP_CYCLES : ISO_CYCLES;
    localparam int unsigned SeqW   = $clog2(SeqMax + 1);
    localparam int unsigned LatW   = $clog2(LATENCY + 1);
    localparam int unsigned ShW    = $clog2(WIDTH);

    localparam logic [2:0] StOff    = 3'd0;
    localparam logic [2:0] StPwrUp  = 3'd1;
    localparam logic [2:0] StIsoRel = 3'd2;
    localparam logic [2:0] StOn     = 3'd3;
    localparam logic [2:0] StIsoSet = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [SeqW-1:0]  seq_cnt_q, seq_cnt_d;
    logic [LatW-1:0]  lat_cnt_q;
    logic             busy_q, done_q, err_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, res_q, alu_out;
    logic [ShW-1:0]   shamt;
    logic             complete, accept, reject;

    // A start may be taken on the very edge the previous operation retires.
    assign complete = busy_q && (lat_cnt_q == LatW'(LATENCY - 1));
    assign accept   = start && (state_q == StOn) && (!busy_q || complete);
    assign reject   = start && !accept;

    always_comb begin
        state_d   = state_q;
        seq_cnt_d = seq_cnt_q;
        case (state_q)
            StOff: begin
                if (pwr_req) begin
                    state_d   = StPwrUp;
                    seq_cnt_d = '0;
                end
            end
            StPwrUp: begin
                if (seq_cnt_q == SeqW'(PWR_UP_CYCLES - 1)) begin
                    state_d   = StIsoRel;
                    seq_cnt_d = '0;
                end else begin
                    seq_cnt_d = seq_cnt_q + SeqW'(1);
                end
            end
            StIsoRel: begin
                if (seq_cnt_q == SeqW'(ISO_CYCLES - 1)) begin
                    state_d   = StOn;
                    seq_cnt_d = '0;
                end else begin
                    seq_cnt_d = seq_cnt_q + SeqW'(1);
                end
            end
            StOn: begin
                // Power-down waits for any in-flight or just-accepted operation.
                if (!pwr_req && !busy_q && !accept) begin
                    state_d   = StIsoSet;
                    seq_cnt_d = '0;
                end
            end
            StIsoSet: begin
                if (seq_cnt_q == SeqW'(ISO_CYCLES - 1)) begin
                    state_d   = StOff;
                    seq_cnt_d = '0;
                end else begin
                    seq_cnt_d = seq_cnt_q + SeqW'(1);
                end
            end
            default: begin
                state_d   = StOff;
                seq_cnt_d = '0;
            end
        endcase
    end

    assign shamt = b_q[ShW-1:0];

    always_comb begin
        alu_out = '0;
        case (op_q)
            4'd0:    alu_out = a_q + b_q;
            4'd1:    alu_out = a_q - b_q;
            4'd2:    alu_out = a_q & b_q;
            4'd3:    alu_out = a_q | b_q;
            4'd4:    alu_out = a_q ^ b_q;
            4'd5:    alu_out = a_q << shamt;
            4'd6:    alu_out = a_q >> shamt;
            4'd7:    alu_out = a_q * b_q;
            default: alu_out = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StOff;
            seq_cnt_q <= '0;
            lat_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            seq_cnt_q <= seq_cnt_d;
            done_q    <= complete;
            err_q     <= reject;

            if (complete) begin
                res_q <= alu_out;
            end else if (state_d == StOff && state_q != StOff) begin
                res_q <= '0; // domain state is lost when the switch opens
            end

            if (accept) begin
                busy_q    <= 1'b1;
                lat_cnt_q <= '0;
                op_q      <= opcode;
                a_q       <= a;
                b_q       <= b;
            end else if (complete) begin
                busy_q    <= 1'b0;
                lat_cnt_q <= '0;
            end else if (busy_q) begin
                lat_cnt_q <= lat_cnt_q + LatW'(1);
            end
        end
    end

    assign pwr_en    = (state_q != StOff);
    assign iso_en    = (state_q != StOn);
    assign pwr_ack   = (state_q == StOn);
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign result    = iso_en ? CLAMP_VAL : res_q;
    assign clamp_obs = CLAMP_VAL;

endmodule

// File: tb/tb_alu_pwr_domain.sv
// Bench for alu_pwr_domain: default instance and a WIDTH=32 fast-sequence
// instance, checked against an arithmetic reference and the timing formulas.
module tb_alu_pwr_domain;

    logic        clk = 1'b0;
    logic        rst0, rst1, pwr_req, start, sel;
    logic [3:0]  opcode;
    logic [31:0] a, b;

    logic        d0_pwr_en, d0_iso_en, d0_pwr_ack, d0_busy, d0_done, d0_err;
    logic [15:0] d0_result, d0_clamp;
    logic        d1_pwr_en, d1_iso_en, d1_pwr_ack, d1_busy, d1_done, d1_err;
    logic [31:0] d1_result, d1_clamp;

    logic        o_pwr_en, o_iso_en, o_pwr_ack, o_busy, o_done, o_err;
    logic [31:0] o_result, o_clamp;

    int vectors = 0;
    int miscompares = 0;
    int unsigned cur_w, cur_lat, cur_pu, cur_iso;
    logic [31:0] cur_clamp;

    always #5 clk = ~clk;

    alu_pwr_domain u_dut0 (
        .clk(clk), .rst(rst0), .pwr_req(pwr_req), .start(start), .opcode(opcode),
        .a(a[15:0]), .b(b[15:0]), .pwr_en(d0_pwr_en), .iso_en(d0_iso_en),
        .pwr_ack(d0_pwr_ack), .busy(d0_busy), .done(d0_done), .err(d0_err),
        .result(d0_result), .clamp_obs(d0_clamp)
    );

    alu_pwr_domain #(
        .WIDTH(32), .CLAMP_VAL(32'h0000_DEAD), .PWR_UP_CYCLES(1), .ISO_CYCLES(1), .LATENCY(1)
    ) u_dut1 (
        .clk(clk), .rst(rst1), .pwr_req(pwr_req), .start(start), .opcode(opcode),
        .a(a), .b(b), .pwr_en(d1_pwr_en), .iso_en(d1_iso_en),
        .pwr_ack(d1_pwr_ack), .busy(d1_busy), .done(d1_done), .err(d1_err),
        .result(d1_result), .clamp_obs(d1_clamp)
    );

    assign o_pwr_en  = sel ? d1_pwr_en  : d0_pwr_en;
    assign o_iso_en  = sel ? d1_iso_en  : d0_iso_en;
    assign o_pwr_ack = sel ? d1_pwr_ack : d0_pwr_ack;
    assign o_busy    = sel ? d1_busy    : d0_busy;
    assign o_done    = sel ? d1_done    : d0_done;
    assign o_err     = sel ? d1_err     : d0_err;
    assign o_result  = sel ? d1_result  : {16'h0, d0_result};
    assign o_clamp   = sel ? d1_clamp   : {16'h0, d0_clamp};

    function automatic logic [31:0] alu_ref(input int unsigned w, input logic [3:0] op,
                                            input logic [31:0] x, input logic [31:0] y);
        logic [63:0] m, r, xx, yy;
        int unsigned sh;
        m  = (64'd1 << w) - 64'd1;
        xx = {32'h0, x} & m;
        yy = {32'h0, y} & m;
        sh = yy % w;
        case (op)
            4'd0:    r = xx + yy;
            4'd1:    r = xx - yy;
            4'd2:    r = xx & yy;
            4'd3:    r = xx | yy;
            4'd4:    r = xx ^ yy;
            4'd5:    r = xx << sh;
            4'd6:    r = xx >> sh;
            4'd7:    r = xx * yy;
            default: r = 64'd0;
        endcase
        return 32'(r & m);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pwr_up();
        pwr_req = 1'b1;
        step();
        chk("up_pwr_en", 32'(o_pwr_en), 1);
        chk("up_iso_hold", 32'(o_iso_en), 1);
        for (int i = 1; i <= int'(cur_pu + cur_iso); i++) begin
            step();
            chk("up_iso", 32'(o_iso_en), (i < int'(cur_pu + cur_iso)) ? 1 : 0);
        end
        chk("up_ack", 32'(o_pwr_ack), 1);
        chk("up_result_cleared", o_result, 0);
    endtask

    task automatic pwr_down();
        pwr_req = 1'b0;
        step();
        chk("dn_iso", 32'(o_iso_en), 1);
        chk("dn_ack", 32'(o_pwr_ack), 0);
        chk("dn_result_clamp", o_result, cur_clamp);
        for (int i = 1; i <= int'(cur_iso); i++) begin
            step();
            chk("dn_pwr_en", 32'(o_pwr_en), (i < int'(cur_iso)) ? 1 : 0);
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp);
        opcode = op; a = x; b = y; start = 1'b1;
        step();
        start = 1'b0;
        chk("op_busy", 32'(o_busy), 1);
        chk("op_no_done", 32'(o_done), 0);
        for (int i = 1; i < int'(cur_lat); i++) begin
            step();
            chk("op_busy_wait", 32'(o_busy), 1);
            chk("op_done_early", 32'(o_done), 0);
        end
        step();
        chk("op_done", 32'(o_done), 1);
        chk("op_idle", 32'(o_busy), 0);
        chk("op_result", o_result, exp);
        step();
        chk("op_done_pulse", 32'(o_done), 0);
    endtask

    initial begin
        logic [31:0] x, y, m, prev;
        logic [3:0]  op;

        rst0 = 1'b1; rst1 = 1'b1; sel = 1'b0; pwr_req = 1'b0; start = 1'b0;
        opcode = '0; a = '0; b = '0;
        cur_w = 16; cur_lat = 2; cur_pu = 4; cur_iso = 2; cur_clamp = 32'h0001;

        // Reset and idle
        step(); step();
        rst0 = 1'b0;
        step();
        chk("rst_pwr_en", 32'(o_pwr_en), 0);
        chk("rst_iso_en", 32'(o_iso_en), 1);
        chk("rst_ack", 32'(o_pwr_ack), 0);
        chk("rst_result", o_result, 32'h0001);
        chk("rst_clamp_obs", o_clamp, 32'h0001);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_err", 32'(o_err), 0);

        pwr_up();

        run_op(4'd0, 32'hFFFF, 32'h0002, 32'h0001);
        run_op(4'd7, 32'h0100, 32'h0100, 32'h0000);
        run_op(4'd5, 32'h0001, 32'h0013, 32'h0008);
        run_op(4'd12, 32'h1234, 32'h5678, 32'h0000);

        // Start while busy is dropped; the first operation completes intact
        opcode = 4'd3; a = 32'h00F0; b = 32'h000F; start = 1'b1;
        step();
        chk("ill_busy_accept", 32'(o_busy), 1);
        opcode = 4'd2; a = 32'h0000; b = 32'h0000;
        step();
        start = 1'b0;
        chk("ill_busy_err", 32'(o_err), 1);
        chk("ill_busy_still", 32'(o_busy), 1);
        chk("ill_busy_ack", 32'(o_pwr_ack), 1);
        step();
        chk("ill_busy_err_pulse", 32'(o_err), 0);
        chk("ill_busy_done", 32'(o_done), 1);
        chk("ill_busy_result", o_result, 32'h00FF);
        step();

        m = 32'h0000_FFFF;
        for (int i = 0; i < 16; i++) begin
            op = 4'($urandom_range(0, 15));
            x  = $urandom & m;
            y  = $urandom & m;
            run_op(op, x, y, alu_ref(cur_w, op, x, y));
        end

        // Power-down deferred behind an operation started the same cycle
        opcode = 4'd1; a = 32'h0003; b = 32'h0005; start = 1'b1; pwr_req = 1'b0;
        step();
        start = 1'b0;
        chk("def_busy", 32'(o_busy), 1);
        chk("def_ack0", 32'(o_pwr_ack), 1);
        step();
        chk("def_ack1", 32'(o_pwr_ack), 1);
        step();
        chk("def_done", 32'(o_done), 1);
        chk("def_result", o_result, 32'hFFFE);
        chk("def_iso_low", 32'(o_iso_en), 0);
        step();
        chk("def_iso", 32'(o_iso_en), 1);
        chk("def_clamp", o_result, 32'h0001);
        chk("def_ack_low", 32'(o_pwr_ack), 0);
        step();
        chk("def_pwr_hold", 32'(o_pwr_en), 1);
        step();
        chk("def_pwr_off", 32'(o_pwr_en), 0);

        // Start while OFF
        opcode = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk("ill_off_err", 32'(o_err), 1);
        chk("ill_off_busy", 32'(o_busy), 0);
        chk("ill_off_pwr", 32'(o_pwr_en), 0);
        chk("ill_off_result", o_result, 32'h0001);
        step();
        chk("ill_off_err_pulse", 32'(o_err), 0);

        pwr_up();
        pwr_down();

        // Parameter sweep instance
        rst0 = 1'b1; sel = 1'b1;
        cur_w = 32; cur_lat = 1; cur_pu = 1; cur_iso = 1; cur_clamp = 32'h0000_DEAD;
        step(); step();
        rst1 = 1'b0;
        step();
        chk("p_rst_result", o_result, 32'h0000_DEAD);
        chk("p_rst_clamp_obs", o_clamp, 32'h0000_DEAD);
        chk("p_rst_pwr_en", 32'(o_pwr_en), 0);

        pwr_up();

        prev = '0;
        for (int i = 0; i < 8; i++) begin
            op = 4'($urandom_range(0, 7));
            x  = $urandom;
            y  = $urandom;
            opcode = op; a = x; b = y; start = 1'b1;
            step();
            if (i > 0) begin
                chk("b2b_done", 32'(o_done), 1);
                chk("b2b_result", o_result, prev);
            end
            chk("b2b_busy", 32'(o_busy), 1);
            prev = alu_ref(cur_w, op, x, y);
        end
        start = 1'b0;
        step();
        chk("b2b_last_done", 32'(o_done), 1);
        chk("b2b_last_result", o_result, prev);
        chk("b2b_idle", 32'(o_busy), 0);

        run_op(4'd6, 32'h8000_0000, 32'h0000_003F, 32'h0000_0001);

        // Reset mid-operation
        opcode = 4'd0; a = 32'd1; b = 32'd1; start = 1'b1;
        step();
        start = 1'b0;
        chk("mid_busy", 32'(o_busy), 1);
        rst1 = 1'b1;
        step();
        chk("mid_rst_done", 32'(o_done), 0);
        chk("mid_rst_busy", 32'(o_busy), 0);
        chk("mid_rst_pwr", 32'(o_pwr_en), 0);
        chk("mid_rst_iso", 32'(o_iso_en), 1);
        chk("mid_rst_result", o_result, 32'h0000_DEAD);
        rst1 = 1'b0; pwr_req = 1'b0;
        step();
        chk("mid_after_done", 32'(o_done), 0);
        chk("mid_after_pwr", 32'(o_pwr_en), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_pwr_domain.md
# alu_pwr_domain

Parametrised, power-gated ALU domain with an on-chip power sequencer. It generalises the fixed 16-bit clamped ALU wrapper in four ways:
- configurable data width and clamp value;
- a sequenced power-switch/isolation handshake in place of raw enables;
- a multi-cycle start/busy/done ALU pipeline;
- rejection reporting for illegal starts.

It sits between the power-management controller (`pwr_req`) and the always-on datapath consuming `result`.

## Interface
- `WIDTH`, 16: operand/result width, ≥ 8.
- `CLAMP_VAL`, 1: value driven on `result` while isolated; WIDTH bits.
- `PWR_UP_CYCLES`, 4: cycles the switch is on before isolation release begins; ≥ 1.
- `ISO_CYCLES`, 2: isolation settle cycles on both the up and down sequences; ≥ 1.
- `LATENCY`, 2: cycles from start accept to result update; ≥ 1.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pwr_req`  in  1  level; 1 requests the domain on, 0 requests it off.
- `start`  in  1  single-cycle operation request.
- `opcode`  in  4  operation select.
- `a`, `b`  in  WIDTH  operands.
- `pwr_en`  out  1  power-switch enable.
- `iso_en`  out  1  isolation enable; 1 means outputs are clamped.
- `pwr_ack`  out  1  1 only in state ON.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse when `result` updates.
- `err`  out  1  one-cycle pulse when a start is rejected.
- `result`  out  WIDTH  computed value; equals `CLAMP_VAL` whenever `iso_en`=1 (combinational mux after the internal register).
- `clamp_obs`  out  WIDTH  constant `CLAMP_VAL`.

## Operation
- Power FSM states: OFF, PWR_UP, ISO_REL, ON, ISO_SET.
- **OFF**
  - Outputs: `pwr_en`=0, `iso_en`=1.
  - Exit: `pwr_req`=1 → PWR_UP.
- **PWR_UP**
  - Outputs: `pwr_en`=1, `iso_en`=1.
  - Exit: after `PWR_UP_CYCLES` cycles → ISO_REL.
- **ISO_REL**
  - Outputs: `pwr_en`=1, `iso_en`=1.
  - Exit: after `ISO_CYCLES` cycles → ON.
- **ON**
  - Outputs: `pwr_en`=1, `iso_en`=0, `pwr_ack`=1.
  - Exit: `pwr_req`=0 and `busy`=0 → ISO_SET.
  - If `pwr_req`=0 while `busy`=1, the transition is deferred until the operation completes.
- **ISO_SET**
  - Outputs: `iso_en`=1, `pwr_en`=1, `pwr_ack`=0.
  - Exit: after `ISO_CYCLES` cycles → OFF.
- Sequences are not abortable. `pwr_req` is ignored in PWR_UP, ISO_REL and ISO_SET, and is re-evaluated on arrival in ON or OFF.
- On entry to OFF the internal result register clears to 0, modelling state loss.
- Start accept: `start`=1 in ON with `busy`=0. `a`, `b` and `opcode` are captured on that edge.
- Start reject: `start`=1 in any other state, or while `busy`=1. The request is dropped and `err` pulses; no other state changes.
- Opcodes (result truncated to WIDTH bits):
  - 0 ADD, 1 SUB (two's complement wrap), 2 AND, 3 OR, 4 XOR.
  - 5 SHL by `b[$clog2(WIDTH)-1:0]`, 6 logical SHR by the same field.
  - 7 MUL, low WIDTH bits.
  - 8–15: result 0; still completes normally with `done`.

## Timing
- Reset values: state OFF, `pwr_en`=0, `iso_en`=1, `pwr_ack`=0, `busy`=0, `done`=0, `err`=0, internal result 0, hence `result`=`CLAMP_VAL`. All counters 0.
- Reset mid-operation or mid-sequence is immediate on the next edge: all of the above, with no completion `done` pulse.
- Power-up, `pwr_req`=1 sampled in OFF at edge k:
  - `pwr_en`=1 from edge k;
  - `iso_en`=0 and `pwr_ack`=1 from edge k+`PWR_UP_CYCLES`+`ISO_CYCLES`.
- Power-down, `pwr_req`=0 sampled in ON with `busy`=0 at edge k:
  - `iso_en`=1 and `pwr_ack`=0 from edge k;
  - `pwr_en`=0 (OFF) from edge k+`ISO_CYCLES`.
- Operation accepted at edge k:
  - `busy`=1 from edge k;
  - at edge k+`LATENCY`: result register updated, `done`=1 for one cycle, `busy`=0.
- Back-to-back: a `start` sampled at edge k+`LATENCY` is accepted, giving full throughput of one operation per `LATENCY` cycles.
- `err` is asserted for one cycle at the edge after the rejected `start` is sampled.
- Isolation ordering: `iso_en` rises no later than `pwr_ack` falls and stays 1 for the whole time `pwr_en`=0. `iso_en`=0 never coincides with `pwr_en`=0.

## Test plan
1. **Reset and idle:** assert `rst` 2 cycles → `pwr_en`=0, `iso_en`=1, `result`=0x0001, `clamp_obs`=0x0001, `busy`/`done`/`err`=0.
2. **Power-up:** `pwr_req`=1 at edge 0 (defaults) → `pwr_en`=1 at edge 0; `iso_en`=0 and `pwr_ack`=1 at edge 6; `result`=0x0000 (cleared register).
3. **ALU operations:** in ON, start ADD a=0xFFFF b=0x0002 → `done` at +2, `result`=0x0001. Then MUL 0x0100×0x0100 → 0x0000. Then SHL 0x0001 by b=0x0013 (shift field 3) → 0x0008. Then opcode 12 → 0x0000 with `done`.
4. **Illegal starts:** start while `busy`, and start in OFF → `err` pulses once each; `busy`, `result` and FSM unchanged.
5. **Deferred power-down:** start SUB 3−5, drop `pwr_req` the same cycle → `done` with `result`=0xFFFE, then `iso_en`=1 and `result`=0x0001, then `pwr_en`=0 2 cycles later. Re-request → `result`=0 after `pwr_ack`.
6. **Parameter sweep:** WIDTH=32, CLAMP_VAL=0xDEAD, LATENCY=1, PWR_UP_CYCLES=1, ISO_CYCLES=1. Isolated `result`=0x0000DEAD; `pwr_ack` 2 cycles after request; back-to-back ops every cycle; reset asserted mid-operation → no `done`, state OFF.
